// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock sequencer.
// Included by the key path, the controller and its interface users.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    OPEN,
    PROG,
    FAIL,
    LOCKOUT
  } lock_state_t;

  localparam logic [3:0] DISP_BLANK = 4'hF;
  localparam logic [3:0] DISP_ERR   = 4'hE;
  localparam logic [3:0] DISP_PROG  = 4'hC;
  localparam logic [3:0] DISP_OPEN  = 4'h0;
  localparam logic [3:0] NO_KEY     = 4'h0;

  // Encoder codes 10..15 carry no key and are folded onto NO_KEY.
  function automatic logic [3:0] key_value(input logic [3:0] k);
    return ((k >= 4'd1) && (k <= 4'd9)) ? k : NO_KEY;
  endfunction

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_ctrl_if.sv
// Keypad-side and display-side signals of the lock controller.
// The controller takes the slave view; whoever drives the keypad takes the master view.
interface lock_ctrl_if;
  logic [3:0] key_num;
  logic       clr;
  logic       set_req;
  logic       unlocked;
  logic       alarm;
  logic [3:0] disp_num;
  logic [3:0] tries;

  modport master (
    output key_num, clr, set_req,
    input  unlocked, alarm, disp_num, tries
  );

  modport slave (
    input  key_num, clr, set_req,
    output unlocked, alarm, disp_num, tries
  );
endinterface

// File: rtl/lock_ctrl_key_event.sv
// Two-flop synchroniser on the encoder code followed by a press edge detector.
// A press is a nonzero digit after a cycle of no key; held or changing keys give no new event.
module key_event
  import lock_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_num,
  output logic       press,
  output logic [3:0] digit
);

  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;
  logic [3:0] prev_reg;
  logic [3:0] key_clean;

  // Invalid codes are masked after the synchroniser so nothing combinational feeds the first flop.
  assign key_clean = key_value(sync2_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= NO_KEY;
      sync2_reg <= NO_KEY;
      prev_reg  <= NO_KEY;
    end else begin
      sync1_reg <= key_num;
      sync2_reg <= sync1_reg;
      prev_reg  <= key_clean;
    end
  end

  assign press = (key_clean != NO_KEY) && (prev_reg == NO_KEY);
  assign digit = key_clean;

endmodule

// File: rtl/lock_ctrl.sv
// Keypad lock sequencer: collects a code, compares it to the stored code,
// drives unlock/alarm/display and allows re-programming the code while open.
module lock_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned CODE_LEN     = 4,
  parameter logic [31:0] DEFAULT_CODE = 32'h0000_1234,
  parameter int unsigned MAX_TRIES    = 3,
  parameter int unsigned UNLOCK_CYC   = 25_000_000,
  parameter int unsigned FAIL_CYC     = 12_500_000,
  parameter int unsigned LOCKOUT_CYC  = 250_000_000,
  parameter int unsigned ENTRY_TO_CYC = 125_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  lock_ctrl_if.slave  bus
);

  localparam int unsigned CODE_W  = 4 * CODE_LEN;
  localparam int unsigned CNT_W   = $clog2(CODE_LEN + 1);
  localparam int unsigned MAX_CYC = max_of(max_of(UNLOCK_CYC, FAIL_CYC),
                                           max_of(LOCKOUT_CYC, ENTRY_TO_CYC));
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // The timer counts down to zero, so a load of N-1 keeps a state for exactly N cycles.
  localparam logic [TMR_W-1:0] UNLOCK_LD = TMR_W'(UNLOCK_CYC - 1);
  localparam logic [TMR_W-1:0] FAIL_LD   = TMR_W'(FAIL_CYC - 1);
  localparam logic [TMR_W-1:0] LOCK_LD   = TMR_W'(LOCKOUT_CYC - 1);
  localparam logic [TMR_W-1:0] ENTRY_LD  = TMR_W'(ENTRY_TO_CYC - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CODE_LEN - 1);
  localparam logic [3:0]       TRIES_MAX = 4'(MAX_TRIES);

  lock_state_t       state_reg;
  logic [TMR_W-1:0]  timer_reg;
  logic [CNT_W-1:0]  digit_cnt_reg;
  logic [CODE_W-1:0] entry_buf_reg;
  logic [CODE_W-1:0] entry_buf_next;
  logic [CODE_W-1:0] code_reg;
  logic              unlocked_reg;
  logic              alarm_reg;
  logic [3:0]        disp_reg;
  logic [3:0]        tries_reg;

  logic              press;
  logic [3:0]        digit;
  logic              timer_done;
  logic              last_digit;
  logic [3:0]        tries_inc;

  key_event u_key_event (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_num (bus.key_num),
    .press   (press),
    .digit   (digit)
  );

  // Buffer with the current digit dropped into the slot selected by the digit count.
  for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_slot
    localparam int unsigned LSB = 4 * (CODE_LEN - 1 - gi);
    assign entry_buf_next[LSB +: 4] = (digit_cnt_reg == CNT_W'(gi)) ? digit
                                                                     : entry_buf_reg[LSB +: 4];
  end

  assign timer_done = (timer_reg == '0);
  assign last_digit = (digit_cnt_reg == LAST_CNT);
  assign tries_inc  = (tries_reg < TRIES_MAX) ? tries_reg + 4'd1 : tries_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      digit_cnt_reg <= '0;
      entry_buf_reg <= '0;
      code_reg      <= DEFAULT_CODE[CODE_W-1:0];
      unlocked_reg  <= 1'b0;
      alarm_reg     <= 1'b0;
      disp_reg      <= DISP_BLANK;
      tries_reg     <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (press && !bus.clr) begin
            entry_buf_reg <= entry_buf_next;
            disp_reg      <= digit;
            timer_reg     <= ENTRY_LD;
            if (last_digit) begin
              digit_cnt_reg <= '0;
              state_reg     <= CHECK;
            end else begin
              digit_cnt_reg <= digit_cnt_reg + CNT_W'(1);
              state_reg     <= ENTRY;
            end
          end
        end

        ENTRY: begin
          if (bus.clr) begin
            state_reg     <= IDLE;
            entry_buf_reg <= '0;
            digit_cnt_reg <= '0;
            disp_reg      <= DISP_BLANK;
          end else if (press) begin
            entry_buf_reg <= entry_buf_next;
            disp_reg      <= digit;
            timer_reg     <= ENTRY_LD;
            if (last_digit) begin
              digit_cnt_reg <= '0;
              state_reg     <= CHECK;
            end else begin
              digit_cnt_reg <= digit_cnt_reg + CNT_W'(1);
            end
          end else if (timer_done) begin
            state_reg     <= IDLE;
            entry_buf_reg <= '0;
            digit_cnt_reg <= '0;
            disp_reg      <= DISP_BLANK;
          end else begin
            timer_reg <= timer_reg - TMR_W'(1);
          end
        end

        CHECK: begin
          entry_buf_reg <= '0;
          if (entry_buf_reg == code_reg) begin
            state_reg    <= OPEN;
            unlocked_reg <= 1'b1;
            disp_reg     <= DISP_OPEN;
            tries_reg    <= 4'd0;
            timer_reg    <= UNLOCK_LD;
          end else begin
            state_reg <= FAIL;
            disp_reg  <= DISP_ERR;
            tries_reg <= tries_inc;
            timer_reg <= FAIL_LD;
          end
        end

        OPEN: begin
          if (bus.set_req) begin
            state_reg     <= PROG;
            unlocked_reg  <= 1'b0;
            disp_reg      <= DISP_PROG;
            timer_reg     <= ENTRY_LD;
            digit_cnt_reg <= '0;
            entry_buf_reg <= '0;
          end else if (timer_done) begin
            state_reg    <= IDLE;
            unlocked_reg <= 1'b0;
            disp_reg     <= DISP_BLANK;
          end else begin
            timer_reg <= timer_reg - TMR_W'(1);
          end
        end

        PROG: begin
          if (bus.clr) begin
            state_reg     <= IDLE;
            entry_buf_reg <= '0;
            digit_cnt_reg <= '0;
            disp_reg      <= DISP_BLANK;
          end else if (press) begin
            timer_reg <= ENTRY_LD;
            if (last_digit) begin
              code_reg      <= entry_buf_next;
              state_reg     <= IDLE;
              entry_buf_reg <= '0;
              digit_cnt_reg <= '0;
              disp_reg      <= DISP_BLANK;
            end else begin
              entry_buf_reg <= entry_buf_next;
              digit_cnt_reg <= digit_cnt_reg + CNT_W'(1);
              disp_reg      <= digit;
            end
          end else if (timer_done) begin
            state_reg     <= IDLE;
            entry_buf_reg <= '0;
            digit_cnt_reg <= '0;
            disp_reg      <= DISP_BLANK;
          end else begin
            timer_reg <= timer_reg - TMR_W'(1);
          end
        end

        FAIL: begin
          // Reaching the try limit skips the error display and escalates at once.
          if (tries_reg == TRIES_MAX) begin
            state_reg <= LOCKOUT;
            alarm_reg <= 1'b1;
            timer_reg <= LOCK_LD;
          end else if (timer_done) begin
            state_reg <= IDLE;
            disp_reg  <= DISP_BLANK;
          end else begin
            timer_reg <= timer_reg - TMR_W'(1);
          end
        end

        LOCKOUT: begin
          if (timer_done) begin
            state_reg <= IDLE;
            alarm_reg <= 1'b0;
            tries_reg <= 4'd0;
            disp_reg  <= DISP_BLANK;
          end else begin
            timer_reg <= timer_reg - TMR_W'(1);
          end
        end

        default: begin
          state_reg <= IDLE;
          disp_reg  <= DISP_BLANK;
        end
      endcase
    end
  end

  assign bus.unlocked = unlocked_reg;
  assign bus.alarm    = alarm_reg;
  assign bus.disp_num = disp_reg;
  assign bus.tries    = tries_reg;

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl with small cycle parameters; display echoes
// are queued when a key is driven and checked on the digit's write edge.
module tb_lock_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  lock_ctrl_if bus ();

  lock_ctrl #(
    .CODE_LEN     (4),
    .DEFAULT_CODE (32'h0000_1234),
    .MAX_TRIES    (3),
    .UNLOCK_CYC   (20),
    .FAIL_CYC     (10),
    .LOCKOUT_CYC  (50),
    .ENTRY_TO_CYC (40)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold a key 5 cycles then release 3; the digit lands on the 3rd edge.
  task automatic press_key(input logic [3:0] d, input logic [3:0] echo);
    logic [3:0] e;
    bus.key_num = d;
    exp_q.push_back(echo);
    tick(3);
    e = exp_q.pop_front();
    check($sformatf("echo_%0h", d), bus.disp_num, e);
    tick(2);
    bus.key_num = 4'h0;
    tick(3);
  endtask

  // Returns 5 edges after the last digit's write edge.
  task automatic enter_code(input logic [15:0] code, input logic [3:0] last_echo);
    for (int i = 3; i >= 1; i--) begin
      press_key(code[4*i +: 4], code[4*i +: 4]);
    end
    press_key(code[3:0], last_echo);
  endtask

  initial begin
    logic [3:0] e;
    rst_n       = 1'b0;
    bus.key_num = 4'h0;
    bus.clr     = 1'b0;
    bus.set_req = 1'b0;
    tick(2);
    check("rst_disp", bus.disp_num, 4'hF);
    check("rst_unlocked", bus.unlocked, 1'b0);
    check("rst_alarm", bus.alarm, 1'b0);
    check("rst_tries", bus.tries, 4'd0);
    rst_n = 1'b1;
    tick(1);

    // 1: correct default code opens for exactly 20 cycles
    enter_code(16'h1234, 4'h4);
    check("t1_unlocked", bus.unlocked, 1'b1);
    check("t1_disp_open", bus.disp_num, 4'h0);
    check("t1_tries", bus.tries, 4'd0);
    tick(15);
    check("t1_unlocked_last", bus.unlocked, 1'b1);
    tick(1);
    check("t1_relock", bus.unlocked, 1'b0);
    check("t1_disp_blank", bus.disp_num, 4'hF);

    // 2: three wrong entries, then lockout
    for (int k = 1; k <= 2; k++) begin
      enter_code(16'h1235, 4'h5);
      check($sformatf("t2_disp_err%0d", k), bus.disp_num, 4'hE);
      check($sformatf("t2_tries%0d", k), bus.tries, 4'(k));
      check($sformatf("t2_alarm%0d", k), bus.alarm, 1'b0);
      tick(5);
      check($sformatf("t2_err_hold%0d", k), bus.disp_num, 4'hE);
      tick(1);
      check($sformatf("t2_idle%0d", k), bus.disp_num, 4'hF);
    end
    enter_code(16'h1235, 4'h5);
    check("t2_alarm_on", bus.alarm, 1'b1);
    check("t2_tries3", bus.tries, 4'd3);
    check("t2_disp_lock", bus.disp_num, 4'hE);
    press_key(4'h1, 4'hE);
    tick(38);
    check("t2_alarm_last", bus.alarm, 1'b1);
    tick(1);
    check("t2_alarm_off", bus.alarm, 1'b0);
    check("t2_tries_clr", bus.tries, 4'd0);
    check("t2_disp_idle", bus.disp_num, 4'hF);

    // 3: long hold gives one digit; 3->5 without release gives none
    bus.key_num = 4'h7;
    exp_q.push_back(4'h7);
    tick(3);
    e = exp_q.pop_front();
    check("t3_echo7", bus.disp_num, e);
    tick(27);
    bus.key_num = 4'h0;
    tick(3);
    bus.key_num = 4'h3;
    exp_q.push_back(4'h3);
    tick(3);
    e = exp_q.pop_front();
    check("t3_echo3", bus.disp_num, e);
    tick(2);
    bus.key_num = 4'h5;
    exp_q.push_back(4'h3);
    tick(5);
    e = exp_q.pop_front();
    check("t3_no_event5", bus.disp_num, e);
    bus.key_num = 4'h0;
    tick(3);
    press_key(4'h4, 4'h4);
    check("t3_still_entry", bus.disp_num, 4'h4);
    check("t3_tries0", bus.tries, 4'd0);
    press_key(4'h1, 4'h1);
    check("t3_fail", bus.disp_num, 4'hE);
    check("t3_tries1", bus.tries, 4'd1);
    tick(6);

    // 4: reprogram to 9876 while open
    enter_code(16'h1234, 4'h4);
    check("t4_open", bus.unlocked, 1'b1);
    check("t4_tries_clr", bus.tries, 4'd0);
    bus.set_req = 1'b1;
    tick(1);
    bus.set_req = 1'b0;
    check("t4_prog_unlocked", bus.unlocked, 1'b0);
    check("t4_prog_disp", bus.disp_num, 4'hC);
    enter_code(16'h9876, 4'hF);
    enter_code(16'h1234, 4'h4);
    check("t4_old_fails", bus.disp_num, 4'hE);
    check("t4_old_tries", bus.tries, 4'd1);
    tick(6);
    enter_code(16'h9876, 4'h6);
    check("t4_new_opens", bus.unlocked, 1'b1);

    // 6: async reset while open restores the default code
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_async_unlocked", bus.unlocked, 1'b0);
    check("t6_async_disp", bus.disp_num, 4'hF);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    enter_code(16'h1234, 4'h4);
    check("t6_default_opens", bus.unlocked, 1'b1);
    tick(16);
    check("t6_relock", bus.unlocked, 1'b0);
    enter_code(16'h9876, 4'h6);
    check("t6_prog_lost", bus.disp_num, 4'hE);
    check("t6_tries", bus.tries, 4'd1);
    tick(6);

    // 5: entry timeout, then clr beating a simultaneous press
    press_key(4'h1, 4'h1);
    press_key(4'h2, 4'h2);
    tick(34);
    check("t5_before_to", bus.disp_num, 4'h2);
    tick(1);
    check("t5_timeout", bus.disp_num, 4'hF);
    press_key(4'h1, 4'h1);
    bus.key_num = 4'h2;
    tick(2);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    check("t5_clr_wins", bus.disp_num, 4'hF);
    tick(2);
    bus.key_num = 4'h0;
    tick(3);
    enter_code(16'h1234, 4'h4);
    check("t5_buf_empty", bus.unlocked, 1'b1);
    check("t5_tries", bus.tries, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
